// File: rtl/game_pkg.sv
// Shared definitions for the input debouncing path: per-channel FSM encoding and
// default timing constants for a 100 MHz system clock.
package game_pkg;

  typedef enum logic [1:0] {
    ST_LOW  = 2'd0,
    ST_RISE = 2'd1,
    ST_HIGH = 2'd2,
    ST_FALL = 2'd3
  } db_state_e;

  localparam int unsigned DB_10MS   = 1_000_000;
  localparam int unsigned HOLD_1S   = 100_000_000;
  localparam int unsigned CNT_W_DEF = 27;

  // A debounced level is asserted in both stable-high and pending-fall states.
  function automatic logic level_of(input db_state_e st);
    return (st == ST_HIGH) || (st == ST_FALL);
  endfunction

endpackage

// File: rtl/debounce_channel.sv
// One debounced input: 2-flop synchroniser, stability counter FSM, and a
// saturating hold counter that produces a single long-press strobe per press.
module debounce_channel
  import game_pkg::*;
#(
  parameter int unsigned STABLE_CYCLES = DB_10MS,
  parameter int unsigned HOLD_CYCLES   = HOLD_1S,
  parameter int unsigned CNT_W         = CNT_W_DEF
) (
  input  logic clk,
  input  logic rst,
  input  logic en,
  input  logic btn_in,
  output logic btn_db,
  output logic press,
  output logic btn_release,
  output logic long_press
);

  localparam logic [CNT_W-1:0] STABLE_LAST = CNT_W'(STABLE_CYCLES - 1);
  localparam logic [CNT_W-1:0] HOLD_MAX    = CNT_W'(HOLD_CYCLES);
  localparam logic [CNT_W-1:0] CNT_ONE     = CNT_W'(1);

  logic             sync1_q;
  logic             sync2_q;
  db_state_e        state_q;
  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] hold_q;
  logic [CNT_W-1:0] hold_d;
  logic             db_q;
  logic             press_q;
  logic             rel_q;
  logic             long_q;
  logic             hold_run;

  // The synchroniser runs regardless of en so no stale level survives a pause.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
    end else begin
      sync1_q <= btn_in;
      sync2_q <= sync1_q;
    end
  end

  assign hold_run = level_of(state_q) && (hold_q != HOLD_MAX);
  assign hold_d   = hold_q + CNT_ONE;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= ST_LOW;
      cnt_q   <= '0;
      hold_q  <= '0;
      db_q    <= 1'b0;
      press_q <= 1'b0;
      rel_q   <= 1'b0;
      long_q  <= 1'b0;
    end else begin
      press_q <= 1'b0;
      rel_q   <= 1'b0;
      long_q  <= 1'b0;
      if (!en) begin
        cnt_q   <= '0;
        state_q <= db_q ? ST_HIGH : ST_LOW;
      end else begin
        if (hold_run) begin
          hold_q <= hold_d;
          if (hold_d == HOLD_MAX) begin
            long_q <= 1'b1;
          end
        end
        case (state_q)
          ST_LOW: begin
            if (sync2_q) begin
              state_q <= ST_RISE;
              cnt_q   <= CNT_ONE;
            end
          end
          ST_RISE: begin
            if (!sync2_q) begin
              state_q <= ST_LOW;
              cnt_q   <= '0;
            end else if (cnt_q == STABLE_LAST) begin
              state_q <= ST_HIGH;
              db_q    <= 1'b1;
              press_q <= 1'b1;
              cnt_q   <= '0;
              hold_q  <= '0;
            end else begin
              cnt_q <= cnt_q + CNT_ONE;
            end
          end
          ST_HIGH: begin
            if (!sync2_q) begin
              state_q <= ST_FALL;
              cnt_q   <= CNT_ONE;
            end
          end
          ST_FALL: begin
            // Bounce back to high keeps the hold count so long-press timing is unaffected.
            if (sync2_q) begin
              state_q <= ST_HIGH;
              cnt_q   <= '0;
            end else if (cnt_q == STABLE_LAST) begin
              state_q <= ST_LOW;
              db_q    <= 1'b0;
              rel_q   <= 1'b1;
              cnt_q   <= '0;
              hold_q  <= '0;
            end else begin
              cnt_q <= cnt_q + CNT_ONE;
            end
          end
          default: begin
            state_q <= ST_LOW;
            cnt_q   <= '0;
          end
        endcase
      end
    end
  end

  assign btn_db      = db_q;
  assign press       = press_q;
  assign btn_release = rel_q;
  assign long_press  = long_q;

endmodule

// File: rtl/multi_debouncer.sv
// N independent debounce channels packed onto vector ports.
// The release strobe port is btn_release because "release" is a reserved word.
module multi_debouncer
  import game_pkg::*;
#(
  parameter int unsigned CHANNELS      = 4,
  parameter int unsigned STABLE_CYCLES = DB_10MS,
  parameter int unsigned HOLD_CYCLES   = HOLD_1S,
  parameter int unsigned CNT_W         = CNT_W_DEF
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                en,
  input  logic [CHANNELS-1:0] btn_in,
  output logic [CHANNELS-1:0] btn_db,
  output logic [CHANNELS-1:0] press,
  output logic [CHANNELS-1:0] btn_release,
  output logic [CHANNELS-1:0] long_press
);

  for (genvar gi = 0; gi < CHANNELS; gi++) begin : g_ch
    debounce_channel #(
      .STABLE_CYCLES(STABLE_CYCLES),
      .HOLD_CYCLES  (HOLD_CYCLES),
      .CNT_W        (CNT_W)
    ) u_ch (
      .clk        (clk),
      .rst        (rst),
      .en         (en),
      .btn_in     (btn_in[gi]),
      .btn_db     (btn_db[gi]),
      .press      (press[gi]),
      .btn_release(btn_release[gi]),
      .long_press (long_press[gi])
    );
  end

endmodule

// File: tb/tb_multi_debouncer.sv
// Scoreboard bench for multi_debouncer with STABLE_CYCLES=4, HOLD_CYCLES=10.
module tb_multi_debouncer;

  localparam int CH = 4;
  localparam int SIG_DB  = 0;
  localparam int SIG_PR  = 1;
  localparam int SIG_REL = 2;
  localparam int SIG_LP  = 3;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          en  = 1'b0;
  logic [CH-1:0] btn_in = '0;
  logic [CH-1:0] btn_db;
  logic [CH-1:0] press;
  logic [CH-1:0] btn_release;
  logic [CH-1:0] long_press;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;

  typedef struct {
    int    cyc;
    string tag;
    int    ch;
    int    sig;
    logic  val;
  } exp_t;

  exp_t sb_q[$];

  multi_debouncer #(
    .CHANNELS     (CH),
    .STABLE_CYCLES(4),
    .HOLD_CYCLES  (10),
    .CNT_W        (8)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .en         (en),
    .btn_in     (btn_in),
    .btn_db     (btn_db),
    .press      (press),
    .btn_release(btn_release),
    .long_press (long_press)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
    end else begin
      $display("ok   %s: %0h (cycle %0d)", tag, got, cyc);
    end
  endtask

  function automatic logic get_sig(input int sig, input int ch);
    case (sig)
      SIG_DB:  return btn_db[ch];
      SIG_PR:  return press[ch];
      SIG_REL: return btn_release[ch];
      default: return long_press[ch];
    endcase
  endfunction

  task automatic expect_bit(input int c, input string tag, input int ch, input int sig, input logic v);
    exp_t e;
    e.cyc = c; e.tag = tag; e.ch = ch; e.sig = sig; e.val = v;
    sb_q.push_back(e);
  endtask

  task automatic expect_pulse(input int c, input string tag, input int ch, input int sig);
    expect_bit(c - 1, {tag, "_pre"}, ch, sig, 1'b0);
    expect_bit(c, tag, ch, sig, 1'b1);
    expect_bit(c + 1, {tag, "_post"}, ch, sig, 1'b0);
  endtask

  task automatic expect_edge(input int c, input string tag, input int ch, input logic to);
    expect_bit(c - 1, {tag, "_before"}, ch, SIG_DB, ~to);
    expect_bit(c, tag, ch, SIG_DB, to);
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Monitor: pop every scoreboard entry that falls due in this cycle.
  always @(negedge clk) begin
    for (int i = sb_q.size() - 1; i >= 0; i--) begin
      if (sb_q[i].cyc == cyc) begin
        check(sb_q[i].tag, {31'b0, get_sig(sb_q[i].sig, sb_q[i].ch)}, {31'b0, sb_q[i].val});
        sb_q.delete(i);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    int k;
    int kf;

    // Reset with all inputs stuck high.
    en = 1'b1;
    btn_in = 4'hF;
    tick(3);
    check("rst_outputs", {16'b0, btn_db, press, btn_release, long_press}, 32'h0);
    rst = 1'b1;
    k = cyc;
    for (int c = 0; c < CH; c++) begin
      expect_edge(k + 6, $sformatf("s1_db%0d", c), c, 1'b1);
      expect_pulse(k + 6, $sformatf("s1_press%0d", c), c, SIG_PR);
      expect_pulse(k + 16, $sformatf("s1_lp%0d", c), c, SIG_LP);
    end
    tick(22);
    btn_in = 4'h0;
    k = cyc;
    for (int c = 0; c < CH; c++) begin
      expect_edge(k + 6, $sformatf("s1_dbfall%0d", c), c, 1'b0);
      expect_pulse(k + 6, $sformatf("s1_rel%0d", c), c, SIG_REL);
    end
    tick(10);

    // Clean press/release on ch0.
    btn_in[0] = 1'b1;
    k = cyc;
    expect_edge(k + 6, "s2_db0", 0, 1'b1);
    expect_pulse(k + 6, "s2_press0", 0, SIG_PR);
    expect_pulse(k + 16, "s2_lp0", 0, SIG_LP);
    tick(20);
    btn_in[0] = 1'b0;
    k = cyc;
    expect_edge(k + 6, "s2_dbfall0", 0, 1'b0);
    expect_pulse(k + 6, "s2_rel0", 0, SIG_REL);
    tick(10);

    // Bounce on ch1: 2-cycle pulses never satisfy the stability count.
    k = cyc;
    for (int c = k + 1; c <= k + 21; c++) begin
      expect_bit(c, $sformatf("s3_nopress1_c%0d", c - k), 1, SIG_PR, 1'b0);
      expect_bit(c, $sformatf("s3_nodb1_c%0d", c - k), 1, SIG_DB, 1'b0);
    end
    for (int i = 0; i < 8; i++) begin
      btn_in[1] = (i % 2 == 0);
      tick(2);
    end
    btn_in[1] = 1'b1;
    kf = cyc;
    expect_edge(kf + 6, "s3_db1", 1, 1'b1);
    expect_pulse(kf + 6, "s3_press1", 1, SIG_PR);
    expect_pulse(kf + 16, "s3_lp1", 1, SIG_LP);
    tick(20);
    btn_in[1] = 1'b0;
    k = cyc;
    expect_pulse(k + 6, "s3_rel1", 1, SIG_REL);
    tick(10);

    // Long press on ch2 with a one-cycle glitch partway through the hold.
    btn_in[2] = 1'b1;
    k = cyc;
    expect_edge(k + 6, "s4_db2", 2, 1'b1);
    expect_pulse(k + 6, "s4_press2", 2, SIG_PR);
    expect_pulse(k + 16, "s4_lp2", 2, SIG_LP);
    for (int c = k + 7; c <= k + 15; c++) begin
      expect_bit(c, $sformatf("s4_dbhold2_c%0d", c - k), 2, SIG_DB, 1'b1);
      expect_bit(c, $sformatf("s4_norel2_c%0d", c - k), 2, SIG_REL, 1'b0);
    end
    for (int c = k + 18; c <= k + 35; c++) begin
      expect_bit(c, $sformatf("s4_lponce2_c%0d", c - k), 2, SIG_LP, 1'b0);
    end
    tick(8);
    btn_in[2] = 1'b0;
    tick(1);
    btn_in[2] = 1'b1;
    tick(21);
    btn_in[2] = 1'b0;
    k = cyc;
    expect_pulse(k + 6, "s4_rel2", 2, SIG_REL);
    tick(10);

    // en dropped mid-RISE on ch3 restarts counting from zero.
    btn_in[3] = 1'b1;
    k = cyc;
    for (int c = k + 5; c <= k + 9; c++) begin
      expect_bit(c, $sformatf("s5_nodb3_c%0d", c - k), 3, SIG_DB, 1'b0);
      expect_bit(c, $sformatf("s5_nopress3_c%0d", c - k), 3, SIG_PR, 1'b0);
    end
    expect_edge(k + 11, "s5_db3", 3, 1'b1);
    expect_pulse(k + 11, "s5_press3", 3, SIG_PR);
    tick(4);
    en = 1'b0;
    tick(3);
    en = 1'b1;
    tick(6);
    btn_in[3] = 1'b0;
    k = cyc;
    expect_pulse(k + 6, "s5_rel3", 3, SIG_REL);
    tick(20);

    // Asynchronous reset while ch0 is high.
    btn_in[0] = 1'b1;
    k = cyc;
    expect_edge(k + 6, "s6_db0", 0, 1'b1);
    tick(10);
    @(negedge clk);
    #2;
    rst = 1'b0;
    #1;
    check("s6_async_db0", {31'b0, btn_db[0]}, 32'h0);
    check("s6_async_all", {16'b0, btn_db, press, btn_release, long_press}, 32'h0);
    tick(2);
    check("s6_no_release", {28'b0, btn_release}, 32'h0);
    btn_in[0] = 1'b0;
    rst = 1'b1;
    tick(10);
    check("s6_idle_after", {16'b0, btn_db, press, btn_release, long_press}, 32'h0);

    check("sb_drain", sb_q.size(), 32'h0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
